// File: rtl/nibble_add_sched_if.sv
// nibble_add_sched_if
//   Bundles every handshake and bus signal of nibble_add_sched.
//
//   Handshake rule (all three channels: req0, req1, res):
//   a transfer happens on a rising clock edge where valid and ready are both
//   high. Ready may depend combinationally on valid. A producer keeps valid
//   and its payload stable until that edge.
//
//   Ports (grouped):
//     req0_* / req1_*  requester channels: valid, a, b, cin in; ready out
//     slice_*          shared 4-bit adder: a, b, cin out; s, cout in
//     res_*            result channel: valid, sum, cout, id out; ready in
//     dbg_state        FSM state for observation (0 IDLE, 1 RUN, 2 DONE)
//
//   Modports: slave = scheduler side, master = environment side.
interface nibble_add_sched_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
    logic             req1_ready;

    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic             slice_cin;
    logic [3:0]       slice_s;
    logic             slice_cout;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;

    logic [1:0]       dbg_state;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        output slice_a, slice_b, slice_cin,
        input  slice_s, slice_cout,
        output res_valid, res_sum, res_cout, res_id,
        input  res_ready,
        output dbg_state
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  slice_a, slice_b, slice_cin,
        output slice_s, slice_cout,
        input  res_valid, res_sum, res_cout, res_id,
        output res_ready,
        input  dbg_state
    );
endinterface

// File: rtl/nibble_add_sched.sv
// nibble_add_sched
//   Time-shares one external 4-bit adder slice between two requesters.
//   A granted WIDTH-bit add runs nibble-serially, LSB nibble first, with the
//   inter-nibble carry held in a register. FSM: IDLE -> RUN -> DONE -> IDLE.
//
//   Ports:
//     Clock   rising-edge clock
//     Resetn  asynchronous active-low reset; aborts any operation in flight
//     bus     nibble_add_sched_if.slave (requesters, slice, result, dbg_state)
//
//   Timing: accept edge, then WIDTH/4 RUN edges, then res_valid is high.
module nibble_add_sched #(
    parameter int WIDTH = 16
) (
    input  logic                Clock,
    input  logic                Resetn,
    nibble_add_sched_if.slave   bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [NIB-1:0][3:0] a_q;
    logic [NIB-1:0][3:0] b_q;
    logic [NIB-1:0][3:0] sum_q;
    logic [IDXW-1:0]     idx;
    logic                carry;
    logic                last_id;     // requester served most recently
    logic                res_valid_q;
    logic                res_cout_q;
    logic                res_id_q;
    logic                grant0;
    logic                grant1;
    logic                ready0;
    logic                ready1;

    // Round-robin: a lone requester wins; on a tie the one not served last.
    // last_id resets to 1 so requester 0 wins the first tie.
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | last_id);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last_id);
    end

    // Gated by Resetn so nothing is accepted while reset is held.
    assign ready0 = Resetn & (state == IDLE) & grant0;
    assign ready1 = Resetn & (state == IDLE) & grant1;

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;

    // Slice operands are driven only while an add is running.
    always_comb begin
        bus.slice_a   = 4'h0;
        bus.slice_b   = 4'h0;
        bus.slice_cin = 1'b0;
        if (state == RUN) begin
            bus.slice_a   = a_q[idx];
            bus.slice_b   = b_q[idx];
            bus.slice_cin = carry;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            last_id     <= 1'b1;
            res_valid_q <= 1'b0;
            res_cout_q  <= 1'b0;
            res_id_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ready0 | ready1) begin
                        if (ready0) begin
                            a_q      <= bus.req0_a;
                            b_q      <= bus.req0_b;
                            carry    <= bus.req0_cin;
                            res_id_q <= 1'b0;
                        end else begin
                            a_q      <= bus.req1_a;
                            b_q      <= bus.req1_b;
                            carry    <= bus.req1_cin;
                            res_id_q <= 1'b1;
                        end
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx] <= bus.slice_s;
                    carry      <= bus.slice_cout;
                    if (idx == LAST_IDX) begin
                        idx         <= '0;
                        res_cout_q  <= bus.slice_cout;
                        res_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        last_id     <= res_id_q;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = sum_q;
    assign bus.res_cout  = res_cout_q;
    assign bus.res_id    = res_id_q;
    assign bus.dbg_state = state;
endmodule
